pid_plant_io: RTL and testbench
===============================

# pid_plant_io

Plant-side counterpart of the PID controller. It converts the controller's 8-bit `control_signal` into a PWM actuator drive. It also measures the plant through a quadrature encoder and returns an 8-bit `feedback` sample once per sample period. This closes the loop between the controller's output and its feedback input.

## Interface
Parameters:
- `SAMPLE_DIV`, default 1000: clocks per feedback sample period; legal range 2..65535.
- `DELTA_W`, default 16: width of the signed per-period delta counter.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `control_signal`, in, 8: requested duty, unsigned.
- `ctrl_valid`, in, 1: one-cycle strobe; when high, `control_signal` is captured as the pending duty.
- `enc_a`, `enc_b`, in, 1 each: raw quadrature inputs, asynchronous to `clk`.
- `pwm_out`, out, 1: actuator drive.
- `feedback`, out, 8: last completed speed sample.
- `fb_valid`, out, 1: one-cycle pulse when `feedback` updates.
- `position`, out, 16: signed accumulated encoder position.
- `enc_err`, out, 1: sticky flag for illegal quadrature transitions.

## Operation
- **Synchroniser.** `enc_a`/`enc_b` pass through 2-flop synchronisers, then into a previous-state register.
- **Decoder.** Gray sequence 00→01→11→10→00 gives step +1; the reverse gives −1; no change gives 0.
  - A two-bit change (00↔11, 01↔10) gives step 0 and sets `enc_err`.
  - `enc_err` clears only on reset.
- **Position.** `position += step` every cycle, wrapping modulo 2^16.
- **Delta counter.** Signed, `DELTA_W` bits, accumulates `step` and saturates at ±(2^(DELTA_W−1)−1).
- **Sample timer.** Counts 0..SAMPLE_DIV−1. On the edge where the timer equals SAMPLE_DIV−1:
  - `feedback <= clamp(delta + step, 0, 255)`; negative values give 0.
  - `delta <= 0`; the step arriving on that cycle is folded into the closing sample, never lost or double-counted.
  - `fb_valid <= 1` for exactly one cycle.
- **Pending duty.** A `ctrl_valid` capture overwrites the pending register; the last strobe before the period boundary wins.
- **PWM counter.** Counts 0..254 (period 255 clocks).
  - Active duty loads from pending only on the wrap edge (254→0), so there are no glitches or runt pulses.
  - `pwm_out = (pwm_cnt < duty_active)`, registered.
  - Duty 0 gives constant low; duty 255 gives constant high.
- **Simultaneous events.** `ctrl_valid` on the wrap cycle captures the new value into pending. The active duty takes the old pending value, and the new value applies one period later.
- **Reset mid-operation.** All state returns to reset values immediately; no partial sample is emitted.

## Timing
- Reset values:
  - `pwm_out`, `feedback`, `fb_valid`, `position`, `enc_err`: 0.
  - Pending and active duty, PWM counter, sample timer, delta: 0.
- Encoder edge at pin → `position` change: 3 clk edges (2 sync + decode register).
- `ctrl_valid` → `pwm_out` reflects the new duty: from the first cycle after the next 254→0 wrap (worst case 256 cycles).
- First `fb_valid` pulse: the cycle after edge number SAMPLE_DIV following reset release. Subsequent pulses occur every SAMPLE_DIV cycles.
- Quadrature input rate limit: at most one state change per 2 clk cycles.

## Configuration
- `PID_IO_BIDIR_EN` defined:
  - `control_signal` is signed two's complement. Duty = min(|c|,127)<<1, covering 0..254.
  - An extra port `dir_out` (out, 1) drives 1 for negative, registered and updated together with the active duty.
  - `feedback` is signed, clamped to −128..127.
- `PID_IO_BIDIR_EN` undefined: unsigned duty and unsigned feedback clamp exactly as in Operation; no `dir_out` port.

## Structure
- Package `pid_io_pkg` holds:
  - `PWM_MAX` = 254.
  - Quadrature state encoding and step enum (`STEP_NONE`, `STEP_FWD`, `STEP_REV`, `STEP_ERR`).
  - Feedback clamp bounds for both configurations.
- Sub-module `quad_decoder`: synchronisers, previous-state register and step/err output. The top level holds the PWM, timer, delta and position logic.

## Test plan
- Reset, `control_signal`=64 with `ctrl_valid` pulse → after the next wrap, `pwm_out` is high for exactly 64 of each 255 cycles. Duty 0 gives constant low; duty 255 gives constant high.
- Strobe duty 200 then 10 within one PWM period → only 10 is applied at the wrap; no intermediate pulse width appears.
- `SAMPLE_DIV`=100, forward quadrature at 1 step/4 clk → `feedback`=25 with a `fb_valid` pulse every 100 cycles; `position` rises by 25 per sample.
- Reverse rotation → `position` decreases. `feedback`=0 (unsigned build) or −25 (with `PID_IO_BIDIR_EN`).
- Force 00→11 on the encoder → `enc_err`=1 and sticky, `position` unchanged; only `rst_n` low clears it.
- Step landing on the terminal timer cycle → counted in the closing sample, next sample starts at 0. Assert `rst_n` mid-period → all outputs 0 and no `fb_valid` until a full SAMPLE_DIV elapses.

Source files
------------

// File: rtl/pid_io_pkg.sv
// Shared constants, quadrature encodings and helpers for the plant-side PID I/O block.
package pid_io_pkg;

    localparam int unsigned PWM_MAX = 254;

    localparam int FB_MIN_U = 0;
    localparam int FB_MAX_U = 255;
    localparam int FB_MIN_S = -128;
    localparam int FB_MAX_S = 127;

    typedef enum logic [1:0] {
        QS_00 = 2'b00,
        QS_01 = 2'b01,
        QS_11 = 2'b11,
        QS_10 = 2'b10
    } quad_state_e;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_FWD  = 2'd1,
        STEP_REV  = 2'd2,
        STEP_ERR  = 2'd3
    } step_e;

    // Gray order 00->01->11->10->00 is forward; double-bit changes are illegal.
    function automatic step_e quad_step(input quad_state_e prev, input quad_state_e cur);
        step_e s;
        s = STEP_NONE;
        case ({prev, cur})
            {QS_00, QS_01}, {QS_01, QS_11}, {QS_11, QS_10}, {QS_10, QS_00}: s = STEP_FWD;
            {QS_00, QS_10}, {QS_10, QS_11}, {QS_11, QS_01}, {QS_01, QS_00}: s = STEP_REV;
            {QS_00, QS_11}, {QS_11, QS_00}, {QS_01, QS_10}, {QS_10, QS_01}: s = STEP_ERR;
            default: s = STEP_NONE;
        endcase
        return s;
    endfunction

    // Signed request -> duty: magnitude capped at 127, doubled to span 0..254.
    function automatic logic [7:0] bidir_duty(input logic [7:0] c);
        logic [7:0] mag;
        mag = c[7] ? (~c + 8'd1) : c;
        if (mag > 8'd127) begin
            mag = 8'd127;
        end
        return {mag[6:0], 1'b0};
    endfunction

endpackage

// File: rtl/pid_plant_io_quad_decoder.sv
// Quadrature front end: 2-flop synchronisers, previous-state register, step and sticky error.
module quad_decoder
    import pid_io_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_enc_a,
    input  logic  i_enc_b,
    output step_e o_step,
    output logic  o_err
);

    logic        r_a_meta;
    logic        r_a_sync;
    logic        r_b_meta;
    logic        r_b_sync;
    quad_state_e r_prev;
    logic        r_err;
    quad_state_e w_cur;
    step_e       w_step;

    always_comb begin
        w_cur  = quad_state_e'({r_a_sync, r_b_sync});
        w_step = quad_step(r_prev, w_cur);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_meta <= 1'b0;
            r_a_sync <= 1'b0;
            r_b_meta <= 1'b0;
            r_b_sync <= 1'b0;
            r_prev   <= QS_00;
            r_err    <= 1'b0;
        end else begin
            r_a_meta <= i_enc_a;
            r_a_sync <= r_a_meta;
            r_b_meta <= i_enc_b;
            r_b_sync <= r_b_meta;
            r_prev   <= w_cur;
            if (w_step == STEP_ERR) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_step = w_step;
    assign o_err  = r_err;

endmodule

// File: rtl/pid_plant_io.sv
// Plant-side PID I/O: PWM actuator drive from control_signal, encoder position and per-period speed feedback.
// Define PID_IO_BIDIR_EN for signed control/feedback and the dir_out port.
module pid_plant_io
    import pid_io_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 1000,
    parameter int unsigned DELTA_W    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  control_signal,
    input  logic        ctrl_valid,
    input  logic        enc_a,
    input  logic        enc_b,
    output logic        pwm_out,
`ifdef PID_IO_BIDIR_EN
    output logic        dir_out,
`endif
    output logic [7:0]  feedback,
    output logic        fb_valid,
    output logic [15:0] position,
    output logic        enc_err
);

    localparam logic [15:0] T_LAST   = 16'(SAMPLE_DIV - 1);
    localparam logic [7:0]  PWM_LAST = 8'(PWM_MAX);
    localparam logic signed [DELTA_W:0] D_MAX = {2'b00, {(DELTA_W-1){1'b1}}};
    localparam logic signed [DELTA_W:0] D_MIN = -D_MAX;

    logic [7:0]          r_pending;
    logic [7:0]          r_duty;
    logic [7:0]          r_pwm_cnt;
    logic [15:0]         r_timer;
    logic [DELTA_W-1:0]  r_delta;

    step_e                   w_step;
    logic                    w_err;
    logic signed [1:0]       w_step_s;
    logic signed [DELTA_W:0] w_delta_sum;
    logic signed [DELTA_W:0] w_delta_sat;
    logic signed [31:0]      w_fb_wide;
    logic [7:0]              w_fb_clamped;
    logic                    w_wrap;
    logic                    w_sample_end;
    logic [7:0]              w_cnt_next;
    logic [7:0]              w_duty_next;

    quad_decoder u_quad (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_enc_a (enc_a),
        .i_enc_b (enc_b),
        .o_step  (w_step),
        .o_err   (w_err)
    );

    assign enc_err = w_err;

    always_comb begin
        w_step_s = 2'sb00;
        case (w_step)
            STEP_FWD: w_step_s = 2'sb01;
            STEP_REV: w_step_s = 2'sb11;
            default:  w_step_s = 2'sb00;
        endcase
    end

    // The step arriving on the terminal timer cycle is folded into the closing sample.
    always_comb begin
        w_delta_sum = {r_delta[DELTA_W-1], r_delta} + {{(DELTA_W-1){w_step_s[1]}}, w_step_s};
        if (w_delta_sum > D_MAX) begin
            w_delta_sat = D_MAX;
        end else if (w_delta_sum < D_MIN) begin
            w_delta_sat = D_MIN;
        end else begin
            w_delta_sat = w_delta_sum;
        end
        w_fb_wide = 32'(w_delta_sat);
    end

`ifdef PID_IO_BIDIR_EN
    always_comb begin
        if (w_fb_wide < FB_MIN_S) begin
            w_fb_clamped = 8'(FB_MIN_S);
        end else if (w_fb_wide > FB_MAX_S) begin
            w_fb_clamped = 8'(FB_MAX_S);
        end else begin
            w_fb_clamped = w_fb_wide[7:0];
        end
    end
`else
    always_comb begin
        if (w_fb_wide < FB_MIN_U) begin
            w_fb_clamped = 8'(FB_MIN_U);
        end else if (w_fb_wide > FB_MAX_U) begin
            w_fb_clamped = 8'(FB_MAX_U);
        end else begin
            w_fb_clamped = w_fb_wide[7:0];
        end
    end
`endif

    always_comb begin
        w_sample_end = (r_timer == T_LAST);
        w_wrap       = (r_pwm_cnt == PWM_LAST);
        w_cnt_next   = w_wrap ? '0 : r_pwm_cnt + 8'd1;
`ifdef PID_IO_BIDIR_EN
        w_duty_next  = w_wrap ? bidir_duty(r_pending) : r_duty;
`else
        w_duty_next  = w_wrap ? r_pending : r_duty;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_duty    <= '0;
            r_pwm_cnt <= '0;
            pwm_out   <= 1'b0;
        end else begin
            if (ctrl_valid) begin
                r_pending <= control_signal;
            end
            r_pwm_cnt <= w_cnt_next;
            r_duty    <= w_duty_next;
            // Compare next-state values so pwm_out stays aligned with the counter it reflects.
            pwm_out   <= (w_cnt_next < w_duty_next);
        end
    end

`ifdef PID_IO_BIDIR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_out <= 1'b0;
        end else if (w_wrap) begin
            dir_out <= r_pending[7];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer  <= '0;
            r_delta  <= '0;
            feedback <= '0;
            fb_valid <= 1'b0;
            position <= '0;
        end else begin
            position <= position + {{14{w_step_s[1]}}, w_step_s};
            fb_valid <= 1'b0;
            if (w_sample_end) begin
                r_timer  <= '0;
                r_delta  <= '0;
                feedback <= w_fb_clamped;
                fb_valid <= 1'b1;
            end else begin
                r_timer  <= r_timer + 16'd1;
                r_delta  <= w_delta_sat[DELTA_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_pid_plant_io.sv
// Directed scoreboard bench for pid_plant_io (default build, SAMPLE_DIV=100).
module tb_pid_plant_io;

    localparam int unsigned SDIV = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  control_signal;
    logic        ctrl_valid;
    logic        enc_a;
    logic        enc_b;
    logic        pwm_out;
    logic [7:0]  feedback;
    logic        fb_valid;
    logic [15:0] position;
    logic        enc_err;

    pid_plant_io #(
        .SAMPLE_DIV (SDIV),
        .DELTA_W    (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .control_signal (control_signal),
        .ctrl_valid     (ctrl_valid),
        .enc_a          (enc_a),
        .enc_b          (enc_b),
        .pwm_out        (pwm_out),
        .feedback       (feedback),
        .fb_valid       (fb_valid),
        .position       (position),
        .enc_err        (enc_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  fb;
        logic [15:0] dpos;
    } exp_t;

    exp_t        sb_q[$];
    int          pwm_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mode = 0;
    int          g = 0;
    int          skip = 0;
    bit          first_check = 1'b0;
    bit          fb_check_en = 1'b1;
    logic        prev_fbv = 1'b0;
    logic [15:0] prev_pos = '0;
    logic [15:0] pos_hold;
    logic [1:0]  gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t        e;
        logic [15:0] dp;
        @(negedge clk);
        cyc++;
        if (prev_fbv) chk("fb_valid_width", 32'(fb_valid), 0);
        if (fb_valid) begin
            if (first_check) begin
                chk("first_fb_cycle", cyc, SDIV);
                first_check = 1'b0;
            end
            dp = position - prev_pos;
            if (fb_check_en) begin
                if (skip > 0) begin
                    skip--;
                end else if (sb_q.size() == 0) begin
                    chk("sb_nonempty", sb_q.size(), 1);
                end else begin
                    e = sb_q.pop_front();
                    chk("feedback", 32'(feedback), 32'(e.fb));
                    chk("pos_delta", 32'(dp), 32'(e.dpos));
                end
            end
            prev_pos = position;
        end
        prev_fbv = fb_valid;
        case (mode)
            1: if (cyc % 4 == 0) g = (g + 1) % 4;
            2: if (cyc % 4 == 0) g = (g + 3) % 4;
            3: if (cyc % SDIV == SDIV - 3) begin
                   g = (g + 1) % 4;
                   mode = 0;
               end
            default: ;
        endcase
        {enc_a, enc_b} = gray[g];
    endtask

    task automatic wait_skip();
        for (int i = 0; i < 400 && skip > 0; i++) tick();
        chk("skip_reached", skip, 0);
    endtask

    task automatic strobe(input logic [7:0] v);
        control_signal = v;
        ctrl_valid = 1'b1;
        tick();
        ctrl_valid = 1'b0;
    endtask

    task automatic pwm_check(input string tag, input bit sync);
        int   hi;
        int   exp;
        bit   found;
        logic prev;
        if (sync) begin
            found = 1'b0;
            prev = pwm_out;
            for (int i = 0; i < 600 && !found; i++) begin
                tick();
                if (!prev && pwm_out) found = 1'b1;
                prev = pwm_out;
            end
            chk({tag, "_sync"}, 32'(found), 1);
        end else begin
            tick();
        end
        hi = int'(pwm_out);
        repeat (254) begin
            tick();
            hi += int'(pwm_out);
        end
        exp = pwm_q.pop_front();
        chk(tag, hi, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        control_signal = '0;
        ctrl_valid = 1'b0;
        enc_a = 1'b0;
        enc_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pwm_out", 32'(pwm_out), 0);
        chk("rst_feedback", 32'(feedback), 0);
        chk("rst_fb_valid", 32'(fb_valid), 0);
        chk("rst_position", 32'(position), 0);
        chk("rst_enc_err", 32'(enc_err), 0);

        rst_n = 1'b1;
        cyc = 0;
        first_check = 1'b1;
        sb_q.push_back('{fb: 8'd0, dpos: 16'd0});
        repeat (105) tick();
        chk("first_fb_seen", 32'(first_check), 0);
        chk("sb_drained_idle", sb_q.size(), 0);

        mode = 1;
        skip = 2;
        wait_skip();
        repeat (3) sb_q.push_back('{fb: 8'd25, dpos: 16'd25});
        repeat (305) tick();
        chk("sb_drained_fwd", sb_q.size(), 0);

        mode = 2;
        skip = 2;
        wait_skip();
        repeat (3) sb_q.push_back('{fb: 8'd0, dpos: 16'hFFE7});
        repeat (305) tick();
        chk("sb_drained_rev", sb_q.size(), 0);
        chk("enc_err_clean", 32'(enc_err), 0);

        mode = 0;
        fb_check_en = 1'b0;
        repeat (20) tick();
        pos_hold = position;
        g = (g + 2) % 4;
        {enc_a, enc_b} = gray[g];
        repeat (6) tick();
        chk("enc_err_set", 32'(enc_err), 1);
        chk("enc_err_pos", 32'(position), 32'(pos_hold));
        repeat (200) tick();
        chk("enc_err_sticky", 32'(enc_err), 1);
        chk("enc_err_pos_hold", 32'(position), 32'(pos_hold));

        fb_check_en = 1'b1;
        skip = 1;
        wait_skip();
        sb_q.push_back('{fb: 8'd1, dpos: 16'd1});
        sb_q.push_back('{fb: 8'd0, dpos: 16'd0});
        mode = 3;
        repeat (210) tick();
        chk("sb_drained_term", sb_q.size(), 0);

        mode = 1;
        fb_check_en = 1'b0;
        for (int i = 0; i < 100 && (cyc % SDIV) != 50; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("rstmid_pwm_out", 32'(pwm_out), 0);
        chk("rstmid_feedback", 32'(feedback), 0);
        chk("rstmid_fb_valid", 32'(fb_valid), 0);
        chk("rstmid_position", 32'(position), 0);
        chk("rstmid_enc_err", 32'(enc_err), 0);
        mode = 0;
        g = 0;
        {enc_a, enc_b} = gray[g];
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        first_check = 1'b1;
        prev_fbv = 1'b0;
        prev_pos = '0;
        skip = 0;
        fb_check_en = 1'b1;
        sb_q.push_back('{fb: 8'd0, dpos: 16'd0});
        repeat (105) tick();
        chk("rstmid_first_fb_seen", 32'(first_check), 0);
        chk("sb_drained_rstmid", sb_q.size(), 0);

        fb_check_en = 1'b0;
        strobe(8'd64);
        pwm_q.push_back(64);
        pwm_q.push_back(64);
        repeat (300) tick();
        pwm_check("pwm_duty64_a", 1'b1);
        pwm_check("pwm_duty64_b", 1'b1);

        tick();
        repeat (5) tick();
        strobe(8'd200);
        repeat (100) tick();
        strobe(8'd10);
        pwm_q.push_back(10);
        pwm_q.push_back(10);
        pwm_check("pwm_last_wins_a", 1'b1);
        pwm_check("pwm_last_wins_b", 1'b1);

        strobe(8'd0);
        pwm_q.push_back(0);
        repeat (520) tick();
        pwm_check("pwm_duty0", 1'b0);

        strobe(8'd255);
        pwm_q.push_back(255);
        repeat (520) tick();
        pwm_check("pwm_duty255", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
